// File: rtl/lsu_seq.sv
// lsu_seq: sequential load/store unit driving a byte-laned synchronous SRAM with RD_LAT read latency.
// Optional macro LSU_MISALIGN_EN: word-crossing accesses run as two beats instead of faulting.
module lsu_seq #(
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_v,
    output logic              req_rdy,
    input  logic [7:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_v,
    output logic              resp_err,
    output logic [31:0]       resp_data,
    output logic              dmem_en,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-3:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata
);
    localparam int WA = ADDR_W - 2;

`ifdef LSU_MISALIGN_EN
    typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, WAIT, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT, RESP} state_t;
`endif

    state_t state_q, state_d;
    logic        req_rdy_q, req_rdy_d, resp_v_q, resp_v_d, resp_err_q, resp_err_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        dmem_en_q, dmem_en_d, dmem_we_q, dmem_we_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic [WA-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic        store_q, store_d, signed_q, signed_d;
    logic [1:0]  size_q, size_d, off_q, off_d;
    logic [RD_LAT-1:0] pipe_v_q, pipe_v_d;

    // Opcode decode: mem_op is one-hot active-low; size code 0=byte, 1=half, 2=word.
    logic [7:0]  op_n;
    logic        op_onehot, op_store, op_signed, req_legal;
    logic [1:0]  op_size;
    logic [3:0]  size_mask;
    logic [31:0] wdata_m;

    assign op_n      = ~mem_op;
    assign op_onehot = (op_n != 8'd0) && ((op_n & (op_n - 8'd1)) == 8'd0);
    assign op_store  = |op_n[7:5];
    assign op_signed = |op_n[1:0];
    assign op_size   = (op_n[7] | op_n[2]) ? 2'd2 :
                       (op_n[6] | op_n[4] | op_n[1]) ? 2'd1 : 2'd0;
    assign size_mask = (op_size == 2'd2) ? 4'hF : (op_size == 2'd1) ? 4'h3 : 4'h1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
        assign wdata_m[8*gi +: 8] = size_mask[gi] ? wdata[8*gi +: 8] : 8'd0;
    end

`ifdef LSU_MISALIGN_EN
    logic [7:0]  lane_m;
    logic [63:0] wdata_rot;
    logic        split_q, split_d;
    logic [3:0]  be1_q, be1_d;
    logic [WA-1:0] addr1_q, addr1_d;
    logic [31:0] wdata1_q, wdata1_d, buf_lo_q, buf_lo_d;
    logic [RD_LAT-1:0] pipe_b1_q, pipe_b1_d;
    logic        cap_b1;

    assign lane_m    = {4'd0, size_mask} << addr[1:0];
    assign wdata_rot = {32'd0, wdata_m} << {addr[1:0], 3'b000};
    assign req_legal = op_onehot;
`else
    logic [3:0]  lane_m;
    logic [31:0] wdata_rot;
    logic        op_aligned;

    assign lane_m     = size_mask << addr[1:0];
    assign wdata_rot  = wdata_m << {addr[1:0], 3'b000};
    assign op_aligned = (op_size == 2'd2) ? (addr[1:0] == 2'b00) :
                        (op_size == 2'd1) ? ~addr[0] : 1'b1;
    assign req_legal  = op_onehot & op_aligned;
`endif

    // Read-return tracker: bit k set means a read beat's data arrives k+1 cycles after issue.
    logic rd_issue, cap_v, cap_last;
    assign rd_issue    = dmem_en_q & ~dmem_we_q;
    assign pipe_v_d[0] = rd_issue;
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe_v
        assign pipe_v_d[gi] = pipe_v_q[gi-1];
    end
    assign cap_v = pipe_v_q[RD_LAT-1];

    logic [31:0] ld_word, ld_ext;
`ifdef LSU_MISALIGN_EN
    assign pipe_b1_d[0] = (state_q == ISSUE1);
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe_b1
        assign pipe_b1_d[gi] = pipe_b1_q[gi-1];
    end
    assign cap_b1   = pipe_b1_q[RD_LAT-1];
    assign cap_last = cap_v & (cap_b1 == split_q);
    assign ld_word  = 32'({(cap_b1 ? dmem_rdata : 32'd0), (cap_b1 ? buf_lo_q : dmem_rdata)}
                          >> {off_q, 3'b000});
`else
    assign cap_last = cap_v;
    assign ld_word  = dmem_rdata >> {off_q, 3'b000};
`endif

    always_comb begin
        case (size_q)
            2'd0:    ld_ext = {{24{signed_q & ld_word[7]}}, ld_word[7:0]};
            2'd1:    ld_ext = {{16{signed_q & ld_word[15]}}, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        resp_v_d     = 1'b0;
        resp_err_d   = 1'b0;
        resp_data_d  = 32'd0;
        dmem_en_d    = 1'b0;
        dmem_we_d    = 1'b0;
        dmem_be_d    = 4'd0;
        dmem_addr_d  = '0;
        dmem_wdata_d = 32'd0;
        store_d      = store_q;
        signed_d     = signed_q;
        size_d       = size_q;
        off_d        = off_q;
`ifdef LSU_MISALIGN_EN
        split_d  = split_q;
        be1_d    = be1_q;
        addr1_d  = addr1_q;
        wdata1_d = wdata1_q;
        buf_lo_d = (cap_v & ~cap_b1) ? dmem_rdata : buf_lo_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_v) begin
                    if (req_legal) begin
                        state_d      = ISSUE0;
                        store_d      = op_store;
                        signed_d     = op_signed;
                        size_d       = op_size;
                        off_d        = addr[1:0];
                        dmem_en_d    = 1'b1;
                        dmem_we_d    = op_store;
                        dmem_be_d    = lane_m[3:0];
                        dmem_addr_d  = addr[ADDR_W-1:2];
                        dmem_wdata_d = wdata_rot[31:0];
`ifdef LSU_MISALIGN_EN
                        split_d  = |lane_m[7:4];
                        be1_d    = lane_m[7:4];
                        addr1_d  = addr[ADDR_W-1:2] + WA'(1);
                        wdata1_d = wdata_rot[63:32];
`endif
                    end else begin
                        state_d    = RESP;
                        resp_v_d   = 1'b1;
                        resp_err_d = 1'b1;
                    end
                end
            end
            ISSUE0: begin
`ifdef LSU_MISALIGN_EN
                if (split_q) begin
                    state_d      = ISSUE1;
                    dmem_en_d    = 1'b1;
                    dmem_we_d    = store_q;
                    dmem_be_d    = be1_q;
                    dmem_addr_d  = addr1_q;
                    dmem_wdata_d = wdata1_q;
                end else
`endif
                if (store_q) begin
                    state_d  = RESP;
                    resp_v_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
`ifdef LSU_MISALIGN_EN
            ISSUE1: begin
                if (store_q) begin
                    state_d  = RESP;
                    resp_v_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
`endif
            WAIT: begin
                if (cap_last) begin
                    state_d     = RESP;
                    resp_v_d    = 1'b1;
                    resp_data_d = ld_ext;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_rdy_q    <= 1'b1;
            resp_v_q     <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 32'd0;
            dmem_en_q    <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_be_q    <= 4'd0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= 32'd0;
            store_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= 2'd0;
            off_q        <= 2'd0;
            pipe_v_q     <= '0;
`ifdef LSU_MISALIGN_EN
            split_q   <= 1'b0;
            be1_q     <= 4'd0;
            addr1_q   <= '0;
            wdata1_q  <= 32'd0;
            buf_lo_q  <= 32'd0;
            pipe_b1_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_rdy_q    <= req_rdy_d;
            resp_v_q     <= resp_v_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
            dmem_en_q    <= dmem_en_d;
            dmem_we_q    <= dmem_we_d;
            dmem_be_q    <= dmem_be_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            store_q      <= store_d;
            signed_q     <= signed_d;
            size_q       <= size_d;
            off_q        <= off_d;
            pipe_v_q     <= pipe_v_d;
`ifdef LSU_MISALIGN_EN
            split_q   <= split_d;
            be1_q     <= be1_d;
            addr1_q   <= addr1_d;
            wdata1_q  <= wdata1_d;
            buf_lo_q  <= buf_lo_d;
            pipe_b1_q <= pipe_b1_d;
`endif
        end
    end

    assign req_rdy    = req_rdy_q;
    assign resp_v     = resp_v_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;
    assign dmem_en    = dmem_en_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
endmodule

// File: doc/lsu_seq.md
# lsu_seq

Sequential, parametrised load/store unit for the homebrew RISC-V core, sitting between the execute stage and the data SRAM bank. It accepts one memory operation at a time through a valid/ready handshake. It drives a byte-laned synchronous SRAM port with configurable read latency and returns sign- or zero-extended load data through a response pulse. Unlike the single-cycle combinational memory path, it supports a multi-cycle SRAM and splits misaligned accesses into two beats.

## Interface
- `ADDR_W`, default 17: byte-address width. The word address is `addr[ADDR_W-1:2]`.
- `RD_LAT`, default 1: SRAM read latency in cycles, legal range 1..3.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req_v` in 1: request valid.
- `req_rdy` out 1: request ready; high only in IDLE.
- `mem_op` in 8: one-hot, active-LOW opcode: [7] sw, [6] sh, [5] sb, [4] lhu, [3] lbu, [2] lw, [1] lh, [0] lb.
- `addr` in ADDR_W: byte address.
- `wdata` in 32: store data, least-significant bytes used.
- `resp_v` out 1: one-cycle response pulse; there is no backpressure.
- `resp_err` out 1: set when the request was faulted; qualified by `resp_v`.
- `resp_data` out 32: extended load data; 0 for stores and faults.
- `dmem_en` out 1: SRAM access strobe, active-high.
- `dmem_we` out 1: write when 1, read when 0.
- `dmem_be` out 4: byte-lane enables, active-high.
- `dmem_addr` out ADDR_W-2: word address.
- `dmem_wdata` out 32: lane-aligned write data.
- `dmem_rdata` in 32: read data, valid exactly RD_LAT cycles after a read beat.

## Operation
- Handshake: a request is accepted in cycle T when `req_v & req_rdy`. Request fields are registered at T; inputs are ignored outside acceptance.
- Decode: size n is 1, 2 or 4 bytes. `signed` is set for lb and lh. Offset o is `addr[1:0]`.
- The request is illegal when `mem_op` has zero or more than one low bit. An illegal request performs no SRAM access, gives `resp_v`=1 and `resp_err`=1 at T+1, and returns to IDLE.
- Lane mask: m = ((1<<n)-1) << o, 8 bits wide. Beat0 uses `be` = m[3:0] at word `addr[ADDR_W-1:2]`. Beat1 exists iff m[7:4] != 0; it uses `be` = m[7:4] at the next word, which wraps to 0 at the top of the address range.
- Store data: wdata is masked to n bytes and rotated left by 8·o within 64 bits. The low word goes to beat0 and the high word to beat1.
- Load data: beat rdata is captured into a 64-bit buffer {beat1, beat0}. The buffer is shifted right by 8·o, then the low n bytes are sign- or zero-extended to 32 bits.
- FSM states: IDLE, ISSUE0, ISSUE1, WAIT, RESP.
  - IDLE → ISSUE0 on accept of a legal request.
  - ISSUE0 → ISSUE1 if beat1 exists.
  - ISSUE0 / ISSUE1 → WAIT for loads.
  - ISSUE0 / ISSUE1 → RESP for stores.
  - WAIT counts until the last beat's data has been captured, then goes to RESP.
  - RESP → IDLE.
- `dmem_en` is high only in ISSUE0 and ISSUE1. Reads are pipelined: beat1 is issued while beat0 is in flight.
- Reset values: `req_rdy`=1, `resp_v`=0, `resp_err`=0, `resp_data`=0, `dmem_en`=0, `dmem_we`=0, `dmem_be`=0, `dmem_addr`=0, `dmem_wdata`=0, FSM=IDLE.
- Reset mid-operation: the FSM is aborted and no response is produced. Read data still in flight is discarded. `req_rdy`=1 the cycle after reset is released.

## Timing
- Accept at T, aligned store: the beat is issued at T+1, `resp_v` at T+2.
- Accept at T, aligned load: the beat is issued at T+1, data is captured at the end of T+1+RD_LAT, `resp_v` at T+2+RD_LAT.
- Split access: add one cycle. Stores respond at T+3; loads respond at T+3+RD_LAT.
- The next accept is possible in the cycle after `resp_v` (RESP→IDLE). The throughput bound is one request per (latency+1) cycles.
- `resp_data` and `resp_err` are valid only while `resp_v`=1. Otherwise they hold 0.

## Configuration
- `LSU_MISALIGN_EN` defined:
  - Misaligned accesses (o+n > 4, or o not a multiple of n) are executed as described above. Accesses that stay inside one word but are not naturally aligned use a single beat.
  - The ISSUE1 state and the 64-bit buffer are present.
- `LSU_MISALIGN_EN` undefined:
  - Any access with o not a multiple of n is faulted: no SRAM access, `resp_v` and `resp_err`=1 at T+1.
  - ISSUE1 and the upper 32 buffer bits are not built.

## Test plan
- Reset, then `sw` with addr=0x0010, wdata=0xDEADBEEF → at T+1: `dmem_en`=1, `dmem_we`=1, `be`=4'b1111, `dmem_addr`=0x0004, `dmem_wdata`=0xDEADBEEF. At T+2: `resp_v`=1, `resp_err`=0.
- Memory word 0x0004 = 0x8899AABB, RD_LAT=2: `lb` @0x0013 → `resp_data`=0xFFFFFF88 at T+4. `lbu` @0x0013 → 0x00000088. `lh` @0x0012 → 0xFFFF8899.
- With `LSU_MISALIGN_EN`: `lw` @0x0013, words 0x0004=0x44332211 and 0x0005=0x88776655 → beats at T+1 (be 4'b1000) and T+2 (be 4'b0111). `resp_data`=0x77665544 at T+3+RD_LAT.
- With `LSU_MISALIGN_EN`: `sh` @ the top byte of the address range, wdata=0xABCD → beat0 writes byte 0xCD at lane 3 of the top word; beat1 writes 0xAB at lane 0 of word 0 (wrap).
- Without `LSU_MISALIGN_EN`: `lh` @0x0001 → `dmem_en` stays 0, `resp_v`=1 and `resp_err`=1 at T+1. Separately, illegal `mem_op`=8'hFC → same fault response.
- `lw` accepted, `rst`=0 asserted at T+2 → no `resp_v` ever appears for it, `dmem_en`=0 after reset, `req_rdy`=1 after release.
